// File: rtl/i2c_write_arbiter_if.sv
// Purpose: bundles the requester, engine and status signals of the I2C write arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold request/data until their done pulse; engine reports done/nack.
//
// Modports:
//   slave  - the arbiter: samples requests and engine status, drives grants/engine/status.
//   master - the environment: drives requests and engine status, observes the arbiter.
interface i2c_write_arbiter_if;
    logic        i_req0;
    logic [23:0] i_data0;
    logic        i_req1;
    logic [23:0] i_data1;
    logic        o_done0;
    logic        o_done1;
    logic        o_ok;
    logic        o_eng_start;
    logic [23:0] o_eng_data;
    logic        o_eng_abort;
    logic        i_eng_done;
    logic        i_eng_nack;
    logic        o_busy;
    logic        o_owner;

    modport slave (
        input  i_req0, i_data0, i_req1, i_data1, i_eng_done, i_eng_nack,
        output o_done0, o_done1, o_ok, o_eng_start, o_eng_data, o_eng_abort,
               o_busy, o_owner
    );

    modport master (
        output i_req0, i_data0, i_req1, i_data1, i_eng_done, i_eng_nack,
        input  o_done0, o_done1, o_ok, o_eng_start, o_eng_data, o_eng_abort,
               o_busy, o_owner
    );
endinterface

// File: rtl/i2c_write_arbiter.sv
// Purpose: arbitrates two I2C write requesters onto one write engine with retry, timeout and bus-free gap.
// Latency: grant to o_eng_start 1 cycle; engine done to o_doneN 1 cycle; next start >= GAP_CYC+2 cycles after o_doneN.
// Backpressure: requests are held by the requester until o_doneN; one transaction in flight at a time.
//
// Ports: i_clk, i_rst_n (async, active-low) plus interface modport bus.slave carrying
//   requester side  : i_req0/i_data0, i_req1/i_data1 in; o_done0/o_done1/o_ok out
//   engine side     : o_eng_start/o_eng_data/o_eng_abort out; i_eng_done/i_eng_nack in
//   status          : o_busy, o_owner
module i2c_write_arbiter #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int RETRY_MAX   = 2,
    parameter int GAP_CYC     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    i2c_write_arbiter_if.slave    bus
);

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [2:0]  RETRY_LIM  = 3'(RETRY_MAX);
    localparam logic [7:0]  GAP_LAST   = 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] timer;
    logic [2:0]  retry_cnt;
    logic [7:0]  gap_cnt;
    logic        last_owner;

    logic        done0_q;
    logic        done1_q;
    logic        ok_q;
    logic        eng_start_q;
    logic [23:0] eng_data_q;
    logic        eng_abort_q;
    logic        busy_q;
    logic        owner_q;

    // Requester 1 wins when it is alone, or when both ask and requester 0 went last.
    logic grant1;
    assign grant1 = bus.i_req1 & (~bus.i_req0 | ~last_owner);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            timer       <= 16'd0;
            retry_cnt   <= 3'd0;
            gap_cnt     <= 8'd0;
            last_owner  <= 1'b1;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            ok_q        <= 1'b0;
            eng_start_q <= 1'b0;
            eng_data_q  <= 24'h0;
            eng_abort_q <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised only on the transition
            // into the state that owns it, so every pulse lasts exactly one cycle.
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            ok_q        <= 1'b0;
            eng_start_q <= 1'b0;
            eng_abort_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_req0 || bus.i_req1) begin
                        owner_q     <= grant1;
                        eng_data_q  <= grant1 ? bus.i_data1 : bus.i_data0;
                        retry_cnt   <= 3'd0;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    timer <= 16'd0;
                    state <= WAIT;
                end

                WAIT: begin
                    timer <= timer + 16'd1;
                    // Engine completion is checked before the timeout so a done
                    // landing on the last allowed cycle is still honoured.
                    if (bus.i_eng_done) begin
                        if (!bus.i_eng_nack) begin
                            done0_q <= ~owner_q;
                            done1_q <= owner_q;
                            ok_q    <= 1'b1;
                            state   <= DONE;
                        end else if (retry_cnt < RETRY_LIM) begin
                            retry_cnt   <= retry_cnt + 3'd1;
                            eng_start_q <= 1'b1;
                            state       <= ISSUE;
                        end else begin
                            done0_q <= ~owner_q;
                            done1_q <= owner_q;
                            ok_q    <= 1'b0;
                            state   <= DONE;
                        end
                    end else if (timer == TIMER_LAST) begin
                        eng_abort_q <= 1'b1;
                        done0_q     <= ~owner_q;
                        done1_q     <= owner_q;
                        ok_q        <= 1'b0;
                        state       <= DONE;
                    end
                end

                DONE: begin
                    last_owner <= owner_q;
                    gap_cnt    <= 8'd0;
                    state      <= GAP;
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_done0     = done0_q;
    assign bus.o_done1     = done1_q;
    assign bus.o_ok        = ok_q;
    assign bus.o_eng_start = eng_start_q;
    assign bus.o_eng_data  = eng_data_q;
    assign bus.o_eng_abort = eng_abort_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_owner     = owner_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Purpose: directed self-checking bench for i2c_write_arbiter (ACK, round-robin, retry, timeout, reset).
// Latency: expectations are hand-computed cycle offsets relative to observed o_eng_start.
// Backpressure: the bench plays both requesters and the engine; all waits are cycle-bounded.
module tb_i2c_write_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i2c_write_arbiter_if bus();

    i2c_write_arbiter #(
        .TIMEOUT_CYC (16),
        .RETRY_MAX   (2),
        .GAP_CYC     (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_start = 0, n_done0 = 0, n_done1 = 0, n_abort = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.o_eng_start === 1'b1) n_start <= n_start + 1;
        if (bus.o_done0     === 1'b1) n_done0 <= n_done0 + 1;
        if (bus.o_done1     === 1'b1) n_done1 <= n_done1 + 1;
        if (bus.o_eng_abort === 1'b1) n_abort <= n_abort + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0: engine start, 1: any done, 2: abort, 3: not busy
    function automatic logic probe(input int sel);
        case (sel)
            0:       return bus.o_eng_start === 1'b1;
            1:       return (bus.o_done0 === 1'b1) || (bus.o_done1 === 1'b1);
            2:       return bus.o_eng_abort === 1'b1;
            default: return bus.o_busy === 1'b0;
        endcase
    endfunction

    // Looks at the current negedge first, then up to budget further negedges.
    task automatic wait_for(input int sel, input int budget, input string tag, output int at);
        logic got;
        got = 1'b0;
        at  = -1;
        for (int i = 0; i <= budget; i++) begin
            if (probe(sel)) begin
                got = 1'b1;
                at  = cyc;
                break;
            end
            @(negedge clk);
        end
        check(tag, {31'd0, got}, 32'd1);
    endtask

    // Engine response: completion pulse sampled at the end of the n-th cycle after now.
    task automatic eng_pulse(input int n, input logic nack);
        repeat (n) @(negedge clk);
        bus.i_eng_done = 1'b1;
        bus.i_eng_nack = nack;
        @(negedge clk);
        bus.i_eng_done = 1'b0;
        bus.i_eng_nack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int s, d, a, prev_d, b, b2;
        logic exp_own [4];
        exp_own = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst_n          = 1'b0;
        bus.i_req0     = 1'b0;
        bus.i_data0    = 24'h0;
        bus.i_req1     = 1'b0;
        bus.i_data1    = 24'h0;
        bus.i_eng_done = 1'b0;
        bus.i_eng_nack = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",  {31'd0, bus.o_busy},      32'd0);
        check("rst_owner", {31'd0, bus.o_owner},     32'd0);
        check("rst_start", {31'd0, bus.o_eng_start}, 32'd0);
        check("rst_abort", {31'd0, bus.o_eng_abort}, 32'd0);
        check("rst_done",  {30'd0, bus.o_done1, bus.o_done0}, 32'd0);
        check("rst_ok",    {31'd0, bus.o_ok},        32'd0);
        check("rst_data",  {8'd0, bus.o_eng_data},   32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, ACK after 10 cycles
        b  = n_start;
        b2 = n_done1;
        bus.i_data0 = 24'h341E00;
        bus.i_req0  = 1'b1;
        wait_for(0, 20, "t1_start_seen", s);
        check("t1_data",  {8'd0, bus.o_eng_data}, 32'h341E00);
        check("t1_owner", {31'd0, bus.o_owner},   32'd0);
        check("t1_busy",  {31'd0, bus.o_busy},    32'd1);
        eng_pulse(10, 1'b0);
        wait_for(1, 20, "t1_done_seen", d);
        check("t1_done0",   {31'd0, bus.o_done0}, 32'd1);
        check("t1_done1",   {31'd0, bus.o_done1}, 32'd0);
        check("t1_ok",      {31'd0, bus.o_ok},    32'd1);
        check("t1_hold",    {8'd0, bus.o_eng_data}, 32'h341E00);
        check("t1_latency", 32'(d - s), 32'd11);
        @(negedge clk);
        bus.i_req0 = 1'b0;
        eng_pulse(0, 1'b0);   // stray completion during GAP must be ignored
        wait_for(3, 20, "t1_idle_seen", a);
        @(negedge clk);
        check("t1_nstart", 32'(n_start - b), 32'd1);
        check("t1_ndone1", 32'(n_done1 - b2), 32'd0);
        check("t1_busy_idle", {31'd0, bus.o_busy}, 32'd0);

        // Both requesting from reset: round-robin 0,1,0,1 with bus-free gap
        bus.i_data0 = 24'h1A0201;
        bus.i_data1 = 24'h1A0A55;
        bus.i_req0  = 1'b1;
        bus.i_req1  = 1'b1;
        do_reset();
        prev_d = 0;
        for (int t = 0; t < 4; t++) begin
            wait_for(0, 30, "rr_start_seen", s);
            check("rr_owner", {31'd0, bus.o_owner}, {31'd0, exp_own[t]});
            check("rr_data",  {8'd0, bus.o_eng_data},
                  exp_own[t] ? 32'h1A0A55 : 32'h1A0201);
            if (t > 0) check("rr_gap", 32'(s - prev_d), 32'd6);
            eng_pulse(3, 1'b0);
            wait_for(1, 20, "rr_done_seen", d);
            check("rr_done_line", {30'd0, bus.o_done1, bus.o_done0},
                  exp_own[t] ? 32'd2 : 32'd1);
            prev_d = d;
        end
        @(negedge clk);
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        wait_for(3, 20, "rr_idle_seen", a);

        // Engine always NACKs: initial issue plus two retries, then failure
        @(negedge clk);
        b = n_start;
        bus.i_data0 = 24'h3400AA;
        bus.i_req0  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_for(0, 20, "nack_start_seen", s);
            check("nack_data", {8'd0, bus.o_eng_data}, 32'h3400AA);
            eng_pulse(2, 1'b1);
        end
        wait_for(1, 20, "nack_done_seen", d);
        check("nack_done0", {31'd0, bus.o_done0}, 32'd1);
        check("nack_ok",    {31'd0, bus.o_ok},    32'd0);
        @(negedge clk);
        bus.i_req0 = 1'b0;
        wait_for(3, 20, "nack_idle_seen", a);
        @(negedge clk);
        check("nack_nstart", 32'(n_start - b), 32'd3);

        // Silent engine on requester 1: abort after 16 WAIT cycles
        b  = n_start;
        b2 = n_abort;
        bus.i_data1 = 24'h3407F0;
        bus.i_req1  = 1'b1;
        wait_for(0, 20, "to_start_seen", s);
        check("to_owner", {31'd0, bus.o_owner}, 32'd1);
        wait_for(2, 40, "to_abort_seen", a);
        check("to_abort_cyc", 32'(a - s), 32'd17);
        check("to_done1", {31'd0, bus.o_done1}, 32'd1);
        check("to_done0", {31'd0, bus.o_done0}, 32'd0);
        check("to_ok",    {31'd0, bus.o_ok},    32'd0);
        @(negedge clk);
        bus.i_req1 = 1'b0;
        wait_for(3, 20, "to_idle_seen", a);
        @(negedge clk);
        check("to_nstart", 32'(n_start - b), 32'd1);
        check("to_nabort", 32'(n_abort - b2), 32'd1);

        // Done on the timeout cycle wins; request dropped mid-transaction still completes
        b2 = n_abort;
        bus.i_data0 = 24'h340C12;
        bus.i_req0  = 1'b1;
        wait_for(0, 20, "race_start_seen", s);
        bus.i_req0 = 1'b0;
        eng_pulse(16, 1'b0);
        wait_for(1, 20, "race_done_seen", d);
        check("race_done_cyc", 32'(d - s), 32'd17);
        check("race_done0", {31'd0, bus.o_done0},     32'd1);
        check("race_ok",    {31'd0, bus.o_ok},        32'd1);
        check("race_abort", {31'd0, bus.o_eng_abort}, 32'd0);
        wait_for(3, 20, "race_idle_seen", a);
        @(negedge clk);
        check("race_nabort", 32'(n_abort - b2), 32'd0);

        // Reset during WAIT: asynchronous clear, no done, tie then goes to requester 0
        b = n_done0 + n_done1;
        bus.i_req0 = 1'b1;
        bus.i_req1 = 1'b1;
        wait_for(0, 20, "arst_start_seen", s);
        check("arst_owner_pre", {31'd0, bus.o_owner}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'd0, bus.o_busy},    32'd0);
        check("arst_owner", {31'd0, bus.o_owner},   32'd0);
        check("arst_data",  {8'd0, bus.o_eng_data}, 32'd0);
        check("arst_done",  {30'd0, bus.o_done1, bus.o_done0}, 32'd0);
        check("arst_ok",    {31'd0, bus.o_ok},      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_for(0, 20, "arst_restart_seen", s);
        check("arst_tie_owner", {31'd0, bus.o_owner}, 32'd0);
        check("arst_no_done",   32'(n_done0 + n_done1 - b), 32'd0);
        eng_pulse(2, 1'b0);
        wait_for(1, 20, "arst_done_seen", d);
        check("arst_done0", {31'd0, bus.o_done0}, 32'd1);
        @(negedge clk);
        bus.i_req0 = 1'b0;
        bus.i_req1 = 1'b0;
        wait_for(3, 20, "arst_idle_seen", a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
